// File: rtl/bcd_stopwatch.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch
//
// Centisecond stopwatch (SS.cc, 00.00 .. 59.99) feeding four BCD digits to the
// seven-segment scanner. Raw buttons are synchronised, debounced and turned
// into one-cycle press pulses. A run/pause/lap FSM gates a prescaled 10 ms
// tick into a cascaded BCD counter. In LAP the display shows a frozen
// snapshot while the live count keeps advancing.
//
// Ports:
//   clk                   system clock, rising-edge
//   rst                   asynchronous active-high reset
//   btn_start/lap/clear   raw asynchronous push-buttons, active-high
//   data3..data0          tens of s, units of s, tenths, hundredths (BCD)
//   running               high in RUN and LAP
//   lap_active            high in LAP
//   wrap                  one-cycle pulse after the 59.99 -> 00.00 rollover
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module bcd_stopwatch #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_DIV        = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [3:0] data3,
    output logic [3:0] data2,
    output logic [3:0] data1,
    output logic [3:0] data0,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    // CLK_HZ only documents the board clock; it is sanity-checked here.
    if (CLK_HZ < 1 || TICK_DIV < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("bcd_stopwatch: CLK_HZ>=1, TICK_DIV>=2, DEBOUNCE_CYCLES>=2 required");
    end

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    // Button vector index: 0 = start, 1 = lap, 2 = clear.
    logic [2:0]          btn_raw;
    logic [2:0]          sync1_q, sync2_q;
    logic [2:0]          db_q, db_d;
    logic [2:0][DW-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]          db_prev_q, press_q;

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [3:0][3:0]     cnt_q, cnt_d;
    logic [3:0][3:0]     snap_q, snap_d;
    logic [3:0][3:0]     disp_q, disp_d;
    logic                running_q, running_d;
    logic                lap_q, lap_d;
    logic                wrap_q, wrap_d;

    logic                start_p, lap_p, clear_p;
    logic                counting, tick, clear_cnt;

    assign btn_raw = {btn_clear, btn_lap, btn_start};

    // Debounce: count while the synchronised input disagrees with the
    // debounced level; flip on the edge the count would reach the limit.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Coinciding presses: clear beats start beats lap.
    assign clear_p = press_q[2];
    assign start_p = press_q[0] & ~press_q[2];
    assign lap_p   = press_q[1] & ~press_q[0] & ~press_q[2];

    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick     = counting && (presc_q == PRESC_LAST);

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        clear_cnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_p) state_d = RUN;
            end
            RUN: begin
                if (start_p) begin
                    state_d = PAUSE;
                end else if (lap_p) begin
                    state_d = LAP;
                    snap_d  = cnt_q;   // pre-increment value even on a tick edge
                end
            end
            LAP: begin
                if (start_p)    state_d = PAUSE;
                else if (lap_p) state_d = RUN;
            end
            PAUSE: begin
                if (clear_p) begin
                    state_d   = IDLE;
                    clear_cnt = 1'b1;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler: zero in IDLE, free-running in RUN/LAP, frozen in PAUSE.
    always_comb begin
        presc_d = presc_q;
        if (clear_cnt || state_q == IDLE) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Cascaded BCD counter; >= comparisons keep every digit in range.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q[0] >= 4'd9) begin
                cnt_d[0] = 4'd0;
                if (cnt_q[1] >= 4'd9) begin
                    cnt_d[1] = 4'd0;
                    if (cnt_q[2] >= 4'd9) begin
                        cnt_d[2] = 4'd0;
                        cnt_d[3] = (cnt_q[3] >= 4'd5) ? 4'd0 : cnt_q[3] + 4'd1;
                    end else begin
                        cnt_d[2] = cnt_q[2] + 4'd1;
                    end
                end else begin
                    cnt_d[1] = cnt_q[1] + 4'd1;
                end
            end else begin
                cnt_d[0] = cnt_q[0] + 4'd1;
            end
        end
    end

    // Output registers are loaded from next-state values so they track the
    // state and count registers without an extra cycle of lag.
    assign wrap_d    = tick && (cnt_q == 16'h5999);
    assign disp_d    = (state_d == LAP) ? snap_d : cnt_d;
    assign running_d = (state_d == RUN) || (state_d == LAP);
    assign lap_d     = (state_d == LAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_cnt_q  <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            state_q   <= IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            wrap_q    <= wrap_d;
        end
    end

    assign data3      = disp_q[3];
    assign data2      = disp_q[2];
    assign data1      = disp_q[1];
    assign data0      = disp_q[0];
    assign running    = running_q;
    assign lap_active = lap_q;
    assign wrap       = wrap_q;

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Centisecond stopwatch that produces the four BCD digits consumed by the eight-digit seven-segment scanner (data3..data0 = SS.cc, 00.00–59.99). Raw push-buttons are synchronised, debounced and edge-detected internally. A run/pause/lap state machine gates a prescaled 10 ms tick into a cascaded BCD counter. Sits between the board buttons and the display scanner.

## Interface
- CLK_HZ, 100_000_000: system clock frequency; informational only, not used in logic.
- TICK_DIV, 1_000_000: clk cycles per 10 ms tick; must be ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a debounced level changes; must be ≥ 2.
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_start  in  1  raw start/stop button, asynchronous, active-high.
- btn_lap  in  1  raw lap button, asynchronous, active-high.
- btn_clear  in  1  raw clear button, asynchronous, active-high.
- data3  out  4  tens of seconds, 0–5.
- data2  out  4  units of seconds, 0–9.
- data1  out  4  tenths, 0–9.
- data0  out  4  hundredths, 0–9.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- wrap  out  1  one-cycle pulse when the count rolls from 59.99 to 00.00.

## Operation
- Reset (rst=1): state, count, snapshot, prescaler, synchronisers, debouncers and edge detectors clear immediately, without a clock edge. Reset values: state IDLE, all data outputs 0, running=0, lap_active=0, wrap=0.
- Button path, per button:
  - Two-flop synchroniser.
  - Debounce counter. It counts while the synchroniser output differs from the debounced level and resets to 0 when they match. The debounced level flips on the edge at which the counter would reach DEBOUNCE_CYCLES.
  - Registered rising-edge detector. It produces a one-cycle press pulse.
- Pulse priority when pulses coincide: clear > start > lap. The lower-priority pulses are dropped.
- State machine:
  - IDLE: start → RUN. lap and clear are ignored.
  - RUN: start → PAUSE. lap → LAP, and the snapshot register loads the current count on that edge. clear is ignored.
  - LAP: start → PAUSE, and the display returns to the live count. lap → RUN. clear is ignored.
  - PAUSE: start → RUN. clear → IDLE, with count=0 and prescaler=0. lap is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP.
  - Holds its value in PAUSE.
  - Is zero in IDLE.
  - A tick occurs on the edge where the prescaler equals TICK_DIV-1 and the state is RUN or LAP.
- BCD counter, on each tick:
  - hundredths +1; 9 → 0 carries to tenths.
  - tenths 9 → 0 carries to seconds units.
  - seconds units 9 → 0 carries to tens of seconds.
  - tens of seconds 5 → 0 is the full wrap. At 59.99 the next tick gives 00.00 and asserts wrap.
- Invariant: no digit ever holds a value above its range limit.
- Output mux: data3..data0 show the snapshot in LAP and the live count in every other state. The counter keeps advancing in LAP.

## Timing
- All outputs are registered; no combinational path runs from any input to any output.
- Button latency: a raw edge held stable changes the state register 2 (sync) + DEBOUNCE_CYCLES + 2 (edge detect, FSM) cycles after the first clk edge that samples it.
- Any raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no press.
- Holding a button produces exactly one press. Release produces none.
- First tick after IDLE → RUN: TICK_DIV cycles after the state change.
- After PAUSE → RUN: the prescaler resumes from its held value.
- Count update: the digits update on the same edge as the prescaler wraps to 0.
- wrap: high for exactly the one cycle following the rollover edge.
- Tick coinciding with start in RUN: the tick is applied and the state goes to PAUSE on the same edge.
- Tick coinciding with lap in RUN: the snapshot captures the pre-increment count.
- rst asserted mid-run: all outputs reach their reset values immediately. After release, the block stays in IDLE until a start press.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_DIV=5.
- Assert rst mid-count at 12.34 with no clock edge → data3..0=0,0,0,0, running=0 immediately; state IDLE after release.
- Press start (held 10 cycles), wait 100 ticks → data3..0=0,1,0,0, running=1.
- 3-cycle glitches on btn_start, repeated, in IDLE → state stays IDLE, data stays 0000, running=0.
- Run to 59.99 → on the next tick data=0,0,0,0; wrap high for exactly 1 cycle; running stays 1.
- Press lap at 00.37 → data frozen at 0,0,3,7, lap_active=1; after 50 more ticks press lap → data=0,0,8,7 live, lap_active=0.
- clear pressed in RUN → ignored, count continues. Press start (PAUSE), then start and clear in the same cycle → clear wins: IDLE, data=0000, prescaler 0.
